// File: rtl/dual_grant_arbiter.sv
// Two-slot arbiter: picks the two highest-priority unserved requesters
// from a rotating pointer and holds registered grants until done.
module dual_grant_arbiter #(
    parameter int N = 12,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         done_a,
    input  logic         done_b,
    output logic         gnt_a_valid,
    output logic [W-1:0] gnt_a_id,
    output logic         gnt_b_valid,
    output logic [W-1:0] gnt_b_id,
    output logic [N-1:0] gnt_onehot,
    output logic         all_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } slot_state_t;

    slot_state_t  st_a, st_a_nxt;
    slot_state_t  st_b, st_b_nxt;
    logic [W-1:0] id_a, id_a_nxt;
    logic [W-1:0] id_b, id_b_nxt;
    logic [W-1:0] ptr, ptr_nxt;

    logic [N-1:0] cand;
    logic         found1, found2;
    logic [W-1:0] first, second;
    logic         grant_a, grant_b;
    logic [W-1:0] gid_a, gid_b;
    logic [W-1:0] last;

    always_comb begin
        gnt_onehot = '0;
        if (st_a == BUSY) gnt_onehot[id_a] = 1'b1;
        if (st_b == BUSY) gnt_onehot[id_b] = 1'b1;
    end

    assign cand = req & ~gnt_onehot;

    // Walk downward from ptr, wrapping, and keep the first two hits.
    always_comb begin
        logic [W-1:0] idx;
        found1 = 1'b0;
        found2 = 1'b0;
        first  = '0;
        second = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(ptr) >= k) idx = W'(int'(ptr) - k);
            else                idx = W'(int'(ptr) + N - k);
            if (cand[idx]) begin
                if (!found1) begin
                    found1 = 1'b1;
                    first  = idx;
                end else if (!found2) begin
                    found2 = 1'b1;
                    second = idx;
                end
            end
        end
    end

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        gid_a   = first;
        gid_b   = first;
        if (st_a == IDLE && st_b == IDLE) begin
            grant_a = found1;
            grant_b = found2;
            gid_b   = second;
        end else if (st_a == IDLE) begin
            grant_a = found1;
        end else if (st_b == IDLE) begin
            grant_b = found1;
        end
    end

    always_comb begin
        last    = (grant_a && grant_b) ? second : first;
        ptr_nxt = ptr;
        if (grant_a || grant_b) begin
            ptr_nxt = (last == '0) ? W'(N - 1) : last - W'(1);
        end
    end

    always_comb begin
        st_a_nxt = st_a;
        id_a_nxt = id_a;
        unique case (st_a)
            IDLE: if (grant_a) begin
                st_a_nxt = BUSY;
                id_a_nxt = gid_a;
            end
            BUSY: if (done_a) begin
                st_a_nxt = IDLE;
                id_a_nxt = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        st_b_nxt = st_b;
        id_b_nxt = id_b;
        unique case (st_b)
            IDLE: if (grant_b) begin
                st_b_nxt = BUSY;
                id_b_nxt = gid_b;
            end
            BUSY: if (done_b) begin
                st_b_nxt = IDLE;
                id_b_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_a <= IDLE;
            st_b <= IDLE;
            id_a <= '0;
            id_b <= '0;
            ptr  <= W'(N - 1);
        end else begin
            st_a <= st_a_nxt;
            st_b <= st_b_nxt;
            id_a <= id_a_nxt;
            id_b <= id_b_nxt;
            ptr  <= ptr_nxt;
        end
    end

    assign gnt_a_valid = (st_a == BUSY);
    assign gnt_b_valid = (st_b == BUSY);
    assign gnt_a_id    = id_a;
    assign gnt_b_id    = id_b;
    assign all_busy    = gnt_a_valid & gnt_b_valid;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Vector-table bench for dual_grant_arbiter; expected outputs are queued
// at drive time and compared after the following rising edge.
module tb_dual_grant_arbiter;

    localparam int N = 12;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] req;
    logic         done_a, done_b;
    logic         gnt_a_valid, gnt_b_valid;
    logic [W-1:0] gnt_a_id, gnt_b_id;
    logic [N-1:0] gnt_onehot;
    logic         all_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_grant_arbiter #(.N(N), .W(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .done_a      (done_a),
        .done_b      (done_b),
        .gnt_a_valid (gnt_a_valid),
        .gnt_a_id    (gnt_a_id),
        .gnt_b_valid (gnt_b_valid),
        .gnt_b_id    (gnt_b_id),
        .gnt_onehot  (gnt_onehot),
        .all_busy    (all_busy)
    );

    typedef struct {
        logic         rst_n;
        logic [N-1:0] req;
        logic         da;
        logic         db;
        logic         av;
        logic [W-1:0] aid;
        logic         bv;
        logic [W-1:0] bid;
    } vec_t;

    typedef struct {
        int           row;
        logic         av;
        logic [W-1:0] aid;
        logic         bv;
        logic [W-1:0] bid;
        logic [N-1:0] oh;
        logic         busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic void add(logic r, logic [N-1:0] q, logic a, logic b,
                                logic av, int aid, logic bv, int bid);
        vec_t v;
        v.rst_n = r;  v.req = q;  v.da = a;  v.db = b;
        v.av = av;  v.aid = W'(aid);  v.bv = bv;  v.bid = W'(bid);
        tbl.push_back(v);
    endfunction

    function automatic exp_t mk_exp(int row, vec_t v);
        exp_t e;
        e.row = row;
        e.av = v.av;  e.aid = v.aid;  e.bv = v.bv;  e.bid = v.bid;
        e.oh = '0;
        if (v.av) e.oh[v.aid] = 1'b1;
        if (v.bv) e.oh[v.bid] = 1'b1;
        e.busy = v.av & v.bv;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({gnt_a_valid, gnt_a_id, gnt_b_valid, gnt_b_id, gnt_onehot, all_busy}
                !== {e.av, e.aid, e.bv, e.bid, e.oh, e.busy}) begin
                failures++;
                $display("FAIL row%0d: got A=%b/%0d B=%b/%0d oh=%h busy=%b, want A=%b/%0d B=%b/%0d oh=%h busy=%b",
                         e.row, gnt_a_valid, gnt_a_id, gnt_b_valid, gnt_b_id,
                         gnt_onehot, all_busy, e.av, e.aid, e.bv, e.bid, e.oh, e.busy);
            end
            if (gnt_a_valid && gnt_b_valid) begin
                checks++;
                if (gnt_a_id == gnt_b_id) begin
                    failures++;
                    $display("FAIL distinct_ids row%0d: got A=%0d B=%0d, want different",
                             e.row, gnt_a_id, gnt_b_id);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        req     = '0;
        done_a  = 1'b0;
        done_b  = 1'b0;

        // basic pair grant, then A re-grant after done
        add(0, 12'h000, 0, 0, 0, 0, 0, 0);
        add(1, 12'h0A0, 0, 0, 1, 7, 1, 5);
        add(1, 12'h0A0, 1, 0, 0, 0, 1, 5);
        add(1, 12'h0A0, 0, 0, 1, 7, 1, 5);
        // full request rotation
        add(0, 12'h000, 0, 0, 0, 0, 0, 0);
        add(1, 12'hFFF, 0, 0, 1, 11, 1, 10);
        add(1, 12'hFFF, 1, 1, 0, 0, 0, 0);
        add(1, 12'hFFF, 0, 0, 1, 9, 1, 8);
        add(1, 12'hFFF, 1, 1, 0, 0, 0, 0);
        add(1, 12'hFFF, 0, 0, 1, 7, 1, 6);
        add(1, 12'hFFF, 1, 1, 0, 0, 0, 0);
        add(1, 12'hFFF, 0, 0, 1, 5, 1, 4);
        add(1, 12'hFFF, 1, 1, 0, 0, 0, 0);
        add(1, 12'hFFF, 0, 0, 1, 3, 1, 2);
        add(1, 12'hFFF, 1, 1, 0, 0, 0, 0);
        add(1, 12'hFFF, 0, 0, 1, 1, 1, 0);
        add(1, 12'hFFF, 1, 1, 0, 0, 0, 0);
        add(1, 12'hFFF, 0, 0, 1, 11, 1, 10);
        // single requester, then B joins
        add(0, 12'h000, 0, 0, 0, 0, 0, 0);
        add(1, 12'h001, 0, 0, 1, 0, 0, 0);
        add(1, 12'h009, 0, 0, 1, 0, 1, 3);
        add(1, 12'h009, 0, 1, 1, 0, 0, 0);
        // both busy, ignored dones, dropped requests
        add(0, 12'h000, 0, 0, 0, 0, 0, 0);
        add(1, 12'h014, 0, 0, 1, 4, 1, 2);
        add(1, 12'hFFF, 0, 0, 1, 4, 1, 2);
        add(1, 12'hFFF, 0, 0, 1, 4, 1, 2);
        add(1, 12'h000, 0, 1, 1, 4, 0, 0);
        add(1, 12'h000, 0, 1, 1, 4, 0, 0);
        add(1, 12'h000, 1, 0, 0, 0, 0, 0);
        add(1, 12'h000, 1, 0, 0, 0, 0, 0);
        // second pick wraps past index 0 (ptr is 1 here)
        add(1, 12'h401, 0, 0, 1, 0, 1, 10);
        add(1, 12'h000, 0, 1, 1, 0, 0, 0);
        // A frees while B grants at the same edge
        add(1, 12'h020, 1, 0, 0, 0, 1, 5);
        add(1, 12'h010, 0, 0, 1, 4, 1, 5);
        // reset beats a concurrent done
        add(0, 12'h000, 1, 0, 0, 0, 0, 0);
        add(1, 12'h800, 0, 0, 1, 11, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset_n = tbl[i].rst_n;
            req     = tbl[i].req;
            done_a  = tbl[i].da;
            done_b  = tbl[i].db;
            sb.push_back(mk_exp(i, tbl[i]));
        end
        @(negedge clk);
        done_a = 1'b0;
        done_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
